fifo_reader: RTL and testbench
==============================

// Module: fifo_reader
// PURPOSE
//  - Consumer-side engine for the team's fifo: drains words through en_read/empty and presents them on a valid/ready stream.
//  - Sits between a fifo read port and any downstream consumer that may stall.
//  - Hides the fifo's 1-cycle read latency with a 2-entry output buffer.
//  - Sustains 1 word/cycle when out_ready is held high.
// PARAMETERS
//  DATA_WIDTH   1    width of each fifo word / stream word
//  CNT_WIDTH    16   width of word_cnt (only present with FIFO_READER_CNT_EN)
// PORTS
//  clk          in   1           single clock; all logic on rising edge
//  rst          in   1           reset; synchronous, active-low (0 = reset)
//  fifo_empty   in   1           fifo empty flag
//  fifo_en_read out  1           read strobe to fifo
//  fifo_data    in   DATA_WIDTH  fifo read data; valid the cycle after an accepted read
//  out_valid    out  1           out_data holds a word
//  out_ready    in   1           consumer accepts when out_valid&&out_ready
//  out_data     out  DATA_WIDTH  stream word (oldest buffered entry)
//  word_cnt     out  CNT_WIDTH   accepted-transfer count (FIFO_READER_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge):
//    - fifo_en_read=0, out_valid=0, out_data=0.
//    - Buffer emptied; inflight=0; word_cnt=0.
//  - Read issue (combinational):
//    - fifo_en_read = rst && !fifo_empty && (occ + inflight - pop) < 2.
//    - pop = out_valid && out_ready.
//  - inflight register:
//    - Set to fifo_en_read at each edge.
//    - On the following edge, fifo_data is written into the buffer tail.
//  - Latency: fifo word -> out_valid is 2 cycles after the fifo_en_read cycle
//    (1 for fifo, 1 for buffer register).
//  - Buffer: 2-entry FIFO; occ in {0,1,2}.
//    - Pop from head, push at tail.
//    - Simultaneous push+pop leaves occ unchanged.
//  - State machine on occ, with inflight orthogonal:
//    - EMPTY (occ=0): out_valid=0. push -> ONE.
//    - ONE (occ=1):
//      - push && !pop -> FULL.
//      - pop && !push -> EMPTY.
//      - otherwise stay.
//    - FULL (occ=2): pop -> ONE. push is impossible here (read gating guarantees no overflow).
//  - Stall: out_ready=0 holds out_valid/out_data stable until accepted. No word is lost or duplicated.
//  - fifo_empty high: no reads issued; any inflight word still lands.
//  - Reset mid-operation: inflight read discarded. fifo_data in the cycle after reset deassertion is ignored.
//  - Ordering: strict fifo order preserved.
//  - word_cnt increments on every pop and wraps from all-ones to 0.
// CONFIGURATION
//  - FIFO_READER_CNT_EN defined:
//    - word_cnt port and CNT_WIDTH-bit counter are built.
//    - Counter behaves as specified above.
//  - FIFO_READER_CNT_EN undefined:
//    - No word_cnt port, no counter logic.
//    - All other behaviour identical.
// STRUCTURE
//  - Shared package fifo_pkg:
//    - Occupancy state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
//    - get_width helper for width derivation.
//  - Sub-module fifo_reader_buf: 2-entry register buffer (push/pop/occ/head data).
//    fifo_reader keeps issue logic, inflight and the counter.
// TESTING
//  1. Reset hold: rst=0 for 3 cycles with fifo_empty=0 -> fifo_en_read=0, out_valid=0, word_cnt=0.
//  2. Streaming: fifo holds A,B,C,D (DATA_WIDTH=8), out_ready=1.
//     -> en_read on 4 consecutive cycles.
//     -> out_data A..D on consecutive cycles, first word 2 cycles after first en_read.
//  3. Back-pressure: out_ready=0 with 5 words queued.
//     -> exactly 2 reads issued, occ=2, out_data=first word held.
//     -> Raise out_ready: remaining 3 follow in order; no loss or duplicate.
//  4. Empty boundary: fifo_empty rises after 1 read.
//     -> inflight word still appears, then out_valid=0.
//     -> No en_read while fifo_empty=1.
//  5. Mid-reset: assert rst=0 in the cycle after an en_read.
//     -> Returned word is dropped; out_valid=0; next word after reset is the fifo's next word.
//  6. FIFO_READER_CNT_EN with CNT_WIDTH=4: 17 transfers -> word_cnt=1 (wrapped).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo reader: occupancy state encoding,
// buffer depth and a width helper.
package fifo_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_state_e;

   localparam int BUF_DEPTH = 2;

   // Number of bits needed to hold any value in 0..max_val.
   function automatic int get_width(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry output buffer for fifo_reader; entry 0 is always the head, so a
// pop from FULL shifts entry 1 forward.
//
//   state | meaning
//   EMPTY | no word buffered, head_data not meaningful
//   ONE   | entry 0 holds the head word
//   FULL  | entry 0 = head, entry 1 = next word
module fifo_reader_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   output occ_state_e            occ,
   output logic [DATA_WIDTH-1:0] head_data
);

   occ_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
   logic [DATA_WIDTH-1:0] ent1_q, ent1_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= EMPTY;
         ent0_q  <= '0;
         ent1_q  <= '0;
      end else begin
         state_q <= state_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               ent0_d  = push_data;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               ent0_d = push_data;
            end else if (push) begin
               ent1_d  = push_data;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // Read gating never pushes here; a push+pop would still be lossless.
            if (pop) begin
               ent0_d = ent1_q;
               if (push) begin
                  ent1_d = push_data;
               end else begin
                  state_d = ONE;
               end
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   assign occ       = state_q;
   assign head_data = ent0_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a 1-cycle-latency fifo read port into a valid/ready stream at up to
// one word per cycle. Define FIFO_READER_CNT_EN to build the word_cnt counter.
module fifo_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 1
`ifdef FIFO_READER_CNT_EN
   ,
   parameter int CNT_WIDTH  = 16
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_en_read,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_READER_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

   localparam int LVL_W = get_width(BUF_DEPTH + 1);

   occ_state_e            occ;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  inflight_q, inflight_d;
   logic                  pop;
   logic [LVL_W-1:0]      level;

   assign out_valid = (occ != EMPTY);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? head_data : '0;

   // Words already buffered plus the one in flight, less the one leaving now,
   // must leave room so the returning word can never overflow the buffer.
   always_comb begin
      level        = LVL_W'(occ) + LVL_W'(inflight_q) - LVL_W'(pop);
      fifo_en_read = rst && !fifo_empty && (level < LVL_W'(BUF_DEPTH));
      inflight_d   = fifo_en_read;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   fifo_reader_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .pop       (pop),
      .push_data (fifo_data),
      .occ       (occ),
      .head_data (head_data)
   );

`ifdef FIFO_READER_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (pop) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed vector tables, hand sequences
// for reset/empty corners, and randomized traffic against a queue-based model.
module tb_fifo_reader;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          fifo_empty;
   logic          fifo_en_read;
   logic [DW-1:0] fifo_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
`ifdef FIFO_READER_CNT_EN
   logic [CW-1:0] word_cnt;
`endif

   fifo_reader #(
      .DATA_WIDTH (DW)
`ifdef FIFO_READER_CNT_EN
      ,
      .CNT_WIDTH  (CW)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_en_read (fifo_en_read),
      .fifo_data    (fifo_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data)
`ifdef FIFO_READER_CNT_EN
      ,
      .word_cnt     (word_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic          rdy;
      logic          en;
      logic          vld;
      logic [DW-1:0] dat;
   } vec_t;

   vec_t          tv [18];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] q     [$];   // contents of the upstream fifo
   logic [DW-1:0] m_buf [$];   // words the reader should be holding, oldest first
   bit            m_infl;
   int            m_cnt;
   bit            force_empty;
   bit            checking;
   bit            s_rst, s_en, s_valid, s_pop;
   logic [DW-1:0] s_dout, s_fdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic upd_empty();
      fifo_empty = force_empty || (q.size() == 0);
   endtask

   // One clock cycle: compare at the falling edge, advance model and fifo after the rising edge.
   task automatic cycle(input bit use_tv, input int idx);
      bit            e_en, e_pop, e_vld;
      logic [DW-1:0] tmp;
      @(negedge clk);
      e_vld = (m_buf.size() > 0);
      e_pop = e_vld && out_ready;
      e_en  = rst && !fifo_empty && ((m_buf.size() + int'(m_infl) - int'(e_pop)) < 2);
      s_rst   = rst;
      s_en    = fifo_en_read;
      s_valid = out_valid;
      s_dout  = out_data;
      s_fdata = fifo_data;
      s_pop   = out_valid && out_ready;
      if (checking) begin
         chk("en_read", 32'(fifo_en_read), 32'(e_en));
         chk("out_valid", 32'(out_valid), 32'(e_vld));
         if (e_vld) chk("out_data", 32'(out_data), 32'(m_buf[0]));
`ifdef FIFO_READER_CNT_EN
         chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
`endif
      end
      if (use_tv) begin
         chk($sformatf("tv%0d_en", idx), 32'(fifo_en_read), 32'(tv[idx].en));
         chk($sformatf("tv%0d_vld", idx), 32'(out_valid), 32'(tv[idx].vld));
         if (tv[idx].vld) chk($sformatf("tv%0d_dat", idx), 32'(out_data), 32'(tv[idx].dat));
      end
      @(posedge clk);
      #1;
      if (!s_rst) begin
         m_buf.delete();
         m_infl = 1'b0;
         m_cnt  = 0;
      end else begin
         if (m_infl) m_buf.push_back(s_fdata);
         if (e_pop) begin
            tmp   = m_buf.pop_front();
            m_cnt = (m_cnt + 1) % (1 << CW);
         end
         m_infl = e_en;
      end
      if (s_en && q.size() > 0) fifo_data = q.pop_front();
      else fifo_data = DW'($urandom);
      upd_empty();
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      force_empty = 1'b0;
      out_ready   = 1'b0;
      q.delete();
      upd_empty();
      cycle(0, 0);
      cycle(0, 0);
      rst = 1'b1;
   endtask

   initial begin
      int stall_reads;
      int xfers;
      int guard;
      int p;

      tv[0]  = '{1'b1, 1'b1, 1'b0, 8'h00};
      tv[1]  = '{1'b1, 1'b1, 1'b0, 8'h00};
      tv[2]  = '{1'b1, 1'b1, 1'b1, 8'hA1};
      tv[3]  = '{1'b1, 1'b1, 1'b1, 8'hA2};
      tv[4]  = '{1'b1, 1'b0, 1'b1, 8'hA3};
      tv[5]  = '{1'b1, 1'b0, 1'b1, 8'hA4};
      tv[6]  = '{1'b1, 1'b0, 1'b0, 8'h00};
      tv[7]  = '{1'b0, 1'b1, 1'b0, 8'h00};
      tv[8]  = '{1'b0, 1'b1, 1'b0, 8'h00};
      tv[9]  = '{1'b0, 1'b0, 1'b1, 8'hB0};
      tv[10] = '{1'b0, 1'b0, 1'b1, 8'hB0};
      tv[11] = '{1'b0, 1'b0, 1'b1, 8'hB0};
      tv[12] = '{1'b1, 1'b1, 1'b1, 8'hB0};
      tv[13] = '{1'b1, 1'b1, 1'b1, 8'hB1};
      tv[14] = '{1'b1, 1'b1, 1'b1, 8'hB2};
      tv[15] = '{1'b1, 1'b0, 1'b1, 8'hB3};
      tv[16] = '{1'b1, 1'b0, 1'b1, 8'hB4};
      tv[17] = '{1'b1, 1'b0, 1'b0, 8'h00};

      checking    = 1'b0;
      rst         = 1'b0;
      out_ready   = 1'b0;
      force_empty = 1'b0;
      fifo_data   = '0;
      m_infl      = 1'b0;
      m_cnt       = 0;
      q.delete();
      upd_empty();
      cycle(0, 0);
      checking = 1'b1;

      // Reset hold with a non-empty fifo
      q.push_back(8'h11);
      upd_empty();
      for (int i = 0; i < 3; i++) cycle(0, 0);
      chk("rst_hold_en", 32'(s_en), 32'd0);
      chk("rst_hold_valid", 32'(s_valid), 32'd0);
`ifdef FIFO_READER_CNT_EN
      chk("rst_hold_cnt", 32'(word_cnt), 32'd0);
`endif
      do_reset();

      // Streaming A..D
      q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      upd_empty();
      for (int i = 0; i <= 6; i++) begin
         out_ready = tv[i].rdy;
         cycle(1, i);
      end
      do_reset();

      // Back-pressure with five words queued
      q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      upd_empty();
      stall_reads = 0;
      for (int i = 7; i <= 17; i++) begin
         out_ready = tv[i].rdy;
         cycle(1, i);
         if (i <= 11 && s_en) stall_reads++;
      end
      chk("stall_reads", 32'(stall_reads), 32'd2);
      do_reset();

      // Empty rises after one read: inflight word still lands
      q = '{8'h40, 8'h41};
      upd_empty();
      out_ready = 1'b1;
      cycle(0, 0);
      chk("empty_first_en", 32'(s_en), 32'd1);
      force_empty = 1'b1;
      upd_empty();
      cycle(0, 0);
      chk("empty_c1_en", 32'(s_en), 32'd0);
      cycle(0, 0);
      chk("empty_c2_valid", 32'(s_valid), 32'd1);
      chk("empty_c2_data", 32'(s_dout), 32'h40);
      chk("empty_c2_en", 32'(s_en), 32'd0);
      cycle(0, 0);
      chk("empty_c3_valid", 32'(s_valid), 32'd0);
      chk("empty_c3_en", 32'(s_en), 32'd0);
      do_reset();

      // Reset in the cycle after a read: returned word dropped
      q = '{8'h50, 8'h51, 8'h52};
      upd_empty();
      out_ready = 1'b1;
      cycle(0, 0);
      chk("midrst_en", 32'(s_en), 32'd1);
      rst = 1'b0;
      cycle(0, 0);
      rst = 1'b1;
      cycle(0, 0);
      chk("midrst_valid", 32'(s_valid), 32'd0);
      cycle(0, 0);
      chk("midrst_valid2", 32'(s_valid), 32'd0);
      cycle(0, 0);
      chk("midrst_next_valid", 32'(s_valid), 32'd1);
      chk("midrst_next_data", 32'(s_dout), 32'h51);
      do_reset();

      // Randomized traffic with varying back-pressure, empties and resets
      for (int i = 0; i < 3000; i++) begin
         p           = (i / 300) % 3;
         rst         = ($urandom_range(0, 199) != 0);
         out_ready   = ($urandom_range(0, 3) > p);
         force_empty = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 1) q.push_back(DW'($urandom));
         upd_empty();
         cycle(0, 0);
      end
      rst = 1'b1;

`ifdef FIFO_READER_CNT_EN
      // Counter wrap: 17 transfers on a 4-bit counter
      do_reset();
      for (int k = 0; k < 17; k++) q.push_back(DW'(k));
      upd_empty();
      out_ready = 1'b1;
      xfers = 0;
      guard = 0;
      while (xfers < 17 && guard < 60) begin
         cycle(0, 0);
         if (s_pop) xfers++;
         guard++;
      end
      chk("cnt_xfers", 32'(xfers), 32'd17);
      chk("cnt_wrap", 32'(word_cnt), 32'd1);
`else
      xfers = 0;
      guard = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
